pipe_stage_reg: RTL

- Parametrised, multi-stage pipeline register that replaces the hand-written per-boundary register blocks (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a packed control bundle and a packed data bundle with a per-stage valid bit.
- Adds the hazard-handling behaviour that the fixed-width stage registers lack: stall (hold) and flush (bubble insertion).
- Sits between two pipeline stages; the hazard unit drives stall/flush.

---
 rtl/pipe_stage_reg.sv | 115 +++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register with stall/flush and a stall-cycle counter.
// Define PIPE_STAGE_REG_PERF_EN to build the saturating stall counter.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic              out_held,
    output logic [15:0]       perf_stall_cnt
);

    generate
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("pipe_stage_reg: STAGES must be in 1..4");
        end
    endgenerate

    logic              v_q [STAGES];
    logic              v_d [STAGES];
    logic [CTRL_W-1:0] c_q [STAGES];
    logic [CTRL_W-1:0] c_d [STAGES];
    logic [DATA_W-1:0] d_q [STAGES];
    logic [DATA_W-1:0] d_d [STAGES];
    logic              held_q;
    logic              held_d;

    always_comb begin
        held_d = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            v_d[k] = v_q[k];
            c_d[k] = c_q[k];
            d_d[k] = d_q[k];
        end
        priority case (1'b1)
            flush: begin
                // Data is left untouched; only the bubble markers are cleared.
                for (int k = 0; k < STAGES; k++) begin
                    v_d[k] = 1'b0;
                    c_d[k] = '0;
                end
            end
            stall: begin
                held_d = 1'b1;
            end
            default: begin
                v_d[0] = in_valid;
                c_d[0] = in_valid ? in_ctrl : '0;
                d_d[0] = in_data;
                for (int k = 1; k < STAGES; k++) begin
                    v_d[k] = v_q[k-1];
                    c_d[k] = c_q[k-1];
                    d_d[k] = d_q[k-1];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= '0;
                d_q[k] <= '0;
            end
            held_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                c_q[k] <= c_d[k];
                d_q[k] <= d_d[k];
            end
            held_q <= held_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_ctrl  = v_q[STAGES-1] ? c_q[STAGES-1] : '0;
    assign out_data  = d_q[STAGES-1];
    assign out_held  = held_q;

`ifdef PIPE_STAGE_REG_PERF_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stall && !flush && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign perf_stall_cnt = cnt_q;
`else
    assign perf_stall_cnt = 16'h0000;
`endif

endmodule
